forward_ctrl: RTL and testbench
===============================

// Module: forward_ctrl
// PURPOSE
//  Generates the 2-bit forwarding selects (fw) consumed by the EX-stage operand muxes.
//  Select codes: 00 = ID/EX read data, 01 = MEM/WB writeback result, 10 = EX/MEM result.
//  Also detects load-use hazards and raises stall_o.
//  Keeps its own shadow copy of per-stage destination/control state (ID/EX, EX/MEM, MEM/WB).
//  It therefore needs only ID-stage inputs plus pipeline control (flush, hold).
// PARAMETERS
//  REG_AW      5      register address width
//  FW_MEMWB    2'b01  select code: forward MEM/WB result
//  FW_EXMEM    2'b10  select code: forward EX/MEM result
// PORTS
//  clk_i          in   1       clock, all state updates on rising edge
//  rst_i          in   1       asynchronous reset, active-low
//  id_rs_i        in   REG_AW  rs of instruction in ID
//  id_rt_i        in   REG_AW  rt of instruction in ID
//  id_rd_i        in   REG_AW  destination (after RegDst select) of instruction in ID
//  id_regwrite_i  in   1       instruction in ID writes a register
//  id_memread_i   in   1       instruction in ID is a load
//  flush_i        in   1       kill instruction in ID (branch taken)
//  hold_i         in   1       global freeze (memory wait); no shadow register updates
//  fw_a_o         out  2       select for EX operand A (rs path)
//  fw_b_o         out  2       select for EX operand B (rt path)
//  stall_o        out  1       load-use stall: hold PC and IF/ID, bubble into ID/EX
// BEHAVIOUR
//  State: ex_{rs,rt,rd,rw,mr}, mem_{rd,rw,mr}, wb_{rd,rw}.
//  Reset: all state 0 (async, rst_i low), so fw_a_o = fw_b_o = 00 and stall_o = 0.
//  Advance (each edge, hold_i=0):
//   wb  <= mem
//   mem <= ex
//   ex  <= id inputs, or a bubble {rw=0, mr=0, regs=0} when stall_o or flush_i.
//  hold_i=1: no register changes; outputs keep being decoded from the frozen state.
//   hold_i wins over stall_o and flush_i.
//  Forwarding decode (combinational from state, valid for the instruction now in EX).
//  Shown for fw_a_o; fw_b_o is identical using ex_rt.
//   if   mem_rw && mem_rd!=0 && mem_rd==ex_rs  -> FW_EXMEM
//   elif wb_rw  && wb_rd!=0  && wb_rd==ex_rs   -> FW_MEMWB
//   else                                       -> 00
//   EX/MEM has priority over MEM/WB (newest value).
//   Code 11 is never produced.
//  Load-use (combinational from ID inputs and state):
//   stall_o = ex_mr && ex_rd!=0 && (ex_rd==id_rs_i || ex_rd==id_rt_i)
//   Lasts exactly one cycle per hazard: the bubble clears ex_mr.
//   The load then sits in MEM/WB when the consumer reaches EX, so the consumer gets FW_MEMWB.
//  A load in EX/MEM with its consumer in EX cannot occur (stall prevents it).
//   No extra handling is required.
//  Register 0: never forwarded, never stalls, even with rw=1.
//  stall_o and flush_i together: a single bubble enters ID/EX; no double effect.
//  Reset mid-operation: all state clears immediately and outputs return to reset values asynchronously.
//  Latency: forward select and stall are zero-cycle combinational decodes of registered state.
// TESTING
//  1 Reset asserted mid-stream with forward pending -> fw_a_o=fw_b_o=00, stall_o=0 immediately.
//  2 add $1,$2,$3 then add $4,$1,$1 back-to-back -> second in EX: fw_a_o=10, fw_b_o=10.
//  3 add $1; nop; sub $5,$6,$1 -> sub in EX: fw_a_o=00, fw_b_o=01.
//    Also: add $1 twice, then or $7,$1,$0 -> fw_a_o=10 (EX/MEM priority).
//  4 lw $5,0($0) then add $6,$5,$0 -> stall_o=1 for exactly 1 cycle.
//    Bubble in EX (fw=00); add in EX next: fw_a_o=01.
//  5 add $0,$1,$1 then add $2,$0,$0 -> fw=00, stall_o=0.
//    lw $0 followed by a use of $0 -> no stall.
//  6 flush_i with add $1 in ID -> no forwarding of $1 afterwards.
//    hold_i=1 for 3 cycles between producer and consumer -> fw outputs constant; select correct after release.

Source files
------------

// File: rtl/forward_ctrl.sv
// EX-stage operand forwarding selects and load-use stall detection, driven from a
// private shadow of the ID/EX, EX/MEM and MEM/WB destination/control state.

module forward_ctrl_lane #(
    parameter int         REG_AW   = 5,
    parameter logic [1:0] FW_MEMWB = 2'b01,
    parameter logic [1:0] FW_EXMEM = 2'b10
) (
    input  logic [REG_AW-1:0] src_i,
    input  logic [REG_AW-1:0] mem_rd_i,
    input  logic              mem_rw_i,
    input  logic [REG_AW-1:0] wb_rd_i,
    input  logic              wb_rw_i,
    output logic [1:0]        sel_o
);
    logic mem_hit, wb_hit;

    // $0 is hard-wired zero, so a write to it is never a valid forwarding source
    assign mem_hit = mem_rw_i && (mem_rd_i != '0) && (mem_rd_i == src_i);
    assign wb_hit  = wb_rw_i  && (wb_rd_i  != '0) && (wb_rd_i  == src_i);

    always_comb begin
        sel_o = 2'b00;
        if (mem_hit)
            sel_o = FW_EXMEM;
        else if (wb_hit)
            sel_o = FW_MEMWB;
    end
endmodule

module forward_ctrl #(
    parameter int         REG_AW   = 5,
    parameter logic [1:0] FW_MEMWB = 2'b01,
    parameter logic [1:0] FW_EXMEM = 2'b10
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [REG_AW-1:0] id_rs_i,
    input  logic [REG_AW-1:0] id_rt_i,
    input  logic [REG_AW-1:0] id_rd_i,
    input  logic              id_regwrite_i,
    input  logic              id_memread_i,
    input  logic              flush_i,
    input  logic              hold_i,
    output logic [1:0]        fw_a_o,
    output logic [1:0]        fw_b_o,
    output logic              stall_o
);
    localparam int NUM_OPS = 2;

    typedef struct packed {
        logic [REG_AW-1:0] rs;
        logic [REG_AW-1:0] rt;
        logic [REG_AW-1:0] rd;
        logic              rw;
        logic              mr;
    } ex_st_t;

    // Load status is only consulted in EX, so later stages drop it
    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic              rw;
    } late_st_t;

    ex_st_t   ex_q,  ex_d;
    late_st_t mem_q, mem_d;
    late_st_t wb_q,  wb_d;

    logic                           bubble;
    logic [NUM_OPS-1:0][REG_AW-1:0] ex_src;
    logic [NUM_OPS-1:0][1:0]        fw_sel;

    assign stall_o = ex_q.mr && (ex_q.rd != '0) &&
                     ((ex_q.rd == id_rs_i) || (ex_q.rd == id_rt_i));
    assign bubble  = stall_o || flush_i;

    always_comb begin
        ex_d  = ex_q;
        mem_d = mem_q;
        wb_d  = wb_q;
        if (!hold_i) begin
            wb_d  = mem_q;
            mem_d = '{rd: ex_q.rd, rw: ex_q.rw};
            if (bubble)
                ex_d = '0;
            else
                ex_d = '{rs: id_rs_i, rt: id_rt_i, rd: id_rd_i,
                         rw: id_regwrite_i, mr: id_memread_i};
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            ex_q  <= ex_d;
            mem_q <= mem_d;
            wb_q  <= wb_d;
        end
    end

    assign ex_src[0] = ex_q.rs;
    assign ex_src[1] = ex_q.rt;

    for (genvar g = 0; g < NUM_OPS; g++) begin : g_op
        forward_ctrl_lane #(
            .REG_AW  (REG_AW),
            .FW_MEMWB(FW_MEMWB),
            .FW_EXMEM(FW_EXMEM)
        ) u_lane (
            .src_i   (ex_src[g]),
            .mem_rd_i(mem_q.rd),
            .mem_rw_i(mem_q.rw),
            .wb_rd_i (wb_q.rd),
            .wb_rw_i (wb_q.rw),
            .sel_o   (fw_sel[g])
        );
    end

    assign fw_a_o = fw_sel[0];
    assign fw_b_o = fw_sel[1];
endmodule

// File: tb/tb_forward_ctrl.sv
// Directed + randomized check of forward_ctrl against an instruction-level pipeline model.

module tb_forward_ctrl;
    logic       clk_i = 0;
    logic       rst_i = 0;
    logic [4:0] id_rs_i = '0, id_rt_i = '0, id_rd_i = '0;
    logic       id_regwrite_i = 0, id_memread_i = 0, flush_i = 0, hold_i = 0;
    logic [1:0] fw_a_o, fw_b_o;
    logic       stall_o;

    int total = 0;
    int bad   = 0;

    forward_ctrl dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .id_rs_i(id_rs_i), .id_rt_i(id_rt_i), .id_rd_i(id_rd_i),
        .id_regwrite_i(id_regwrite_i), .id_memread_i(id_memread_i),
        .flush_i(flush_i), .hold_i(hold_i),
        .fw_a_o(fw_a_o), .fw_b_o(fw_b_o), .stall_o(stall_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [4:0] rs, rt, rd;
        logic       rw, mr;
    } ins_t;

    // pipe[0]=EX, pipe[1]=EX/MEM, pipe[2]=MEM/WB; older instructions at higher index
    ins_t pipe[3];

    function automatic ins_t bubble_ins();
        ins_t b;
        b.rs = 0; b.rt = 0; b.rd = 0; b.rw = 0; b.mr = 0;
        return b;
    endfunction

    function automatic logic [1:0] ref_fw(logic [4:0] src);
        if (src == 0) return 2'b00;
        for (int s = 1; s < 3; s++)
            if (pipe[s].rw && pipe[s].rd == src)
                return (s == 1) ? 2'b10 : 2'b01;
        return 2'b00;
    endfunction

    function automatic logic ref_stall();
        return pipe[0].mr && pipe[0].rd != 0 &&
               (pipe[0].rd == id_rs_i || pipe[0].rd == id_rt_i);
    endfunction

    task automatic cmp(string tag, logic [1:0] got, logic [1:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%b exp=%b", tag, got, exp);
        end
    endtask

    task automatic check_model(string tag);
        cmp({tag, ".fw_a"}, fw_a_o, ref_fw(pipe[0].rs));
        cmp({tag, ".fw_b"}, fw_b_o, ref_fw(pipe[0].rt));
        cmp({tag, ".stall"}, {1'b0, stall_o}, {1'b0, ref_stall()});
    endtask

    task automatic check_const(string tag, logic [1:0] a, logic [1:0] b, logic s);
        cmp({tag, ".fw_a"}, fw_a_o, a);
        cmp({tag, ".fw_b"}, fw_b_o, b);
        cmp({tag, ".stall"}, {1'b0, stall_o}, {1'b0, s});
    endtask

    // Drive ID for one cycle, check the combinational outputs, then clock the model
    task automatic step(input logic [4:0] rs, rt, rd, input logic rw, mr, fl, hd,
                        input string tag);
        logic st;
        id_rs_i = rs; id_rt_i = rt; id_rd_i = rd;
        id_regwrite_i = rw; id_memread_i = mr; flush_i = fl; hold_i = hd;
        #2;
        check_model(tag);
        st = ref_stall();
        @(posedge clk_i);
        if (!hd) begin
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            if (st || fl) pipe[0] = bubble_ins();
            else begin
                pipe[0].rs = rs; pipe[0].rt = rt; pipe[0].rd = rd;
                pipe[0].rw = rw; pipe[0].mr = mr;
            end
        end
        #1;
    endtask

    task automatic nop(string tag);
        step(0, 0, 0, 0, 0, 0, 0, tag);
    endtask

    task automatic do_reset();
        rst_i = 0;
        #1;
        for (int s = 0; s < 3; s++) pipe[s] = bubble_ins();
        @(posedge clk_i);
        #1 rst_i = 1;
    endtask

    initial begin
        for (int s = 0; s < 3; s++) pipe[s] = bubble_ins();
        #2;
        check_const("reset", 2'b00, 2'b00, 1'b0);
        @(posedge clk_i);
        #1 rst_i = 1;

        // back-to-back dependency: EX/MEM forward on both operands
        step(2, 3, 1, 1, 0, 0, 0, "t2.add1");
        step(1, 1, 4, 1, 0, 0, 0, "t2.add4");
        check_const("t2.exmem", 2'b10, 2'b10, 1'b0);
        nop("t2.n");

        // one gap: MEM/WB forward on rt
        do_reset();
        step(2, 3, 1, 1, 0, 0, 0, "t3.add1");
        nop("t3.nop");
        step(6, 1, 5, 1, 0, 0, 0, "t3.sub");
        check_const("t3.memwb", 2'b00, 2'b01, 1'b0);
        // two writers of $1: newest wins
        step(2, 3, 1, 1, 0, 0, 0, "t3.a");
        step(2, 3, 1, 1, 0, 0, 0, "t3.b");
        step(1, 0, 7, 1, 0, 0, 0, "t3.or");
        check_const("t3.prio", 2'b10, 2'b00, 1'b0);

        // reset mid-stream with a forward pending
        rst_i = 0;
        #1;
        check_const("t1.async_rst", 2'b00, 2'b00, 1'b0);
        for (int s = 0; s < 3; s++) pipe[s] = bubble_ins();
        @(posedge clk_i);
        #1 rst_i = 1;

        // load-use: one stall cycle, then MEM/WB forward
        step(0, 0, 5, 1, 1, 0, 0, "t4.lw");
        id_rs_i = 5; id_rt_i = 0; #1;
        check_const("t4.stall", 2'b00, 2'b00, 1'b1);
        step(5, 0, 6, 1, 0, 0, 0, "t4.add_st");
        step(5, 0, 6, 1, 0, 0, 0, "t4.add_re");
        check_const("t4.after", 2'b01, 2'b00, 1'b0);
        nop("t4.n");

        // register 0 never forwards or stalls
        do_reset();
        step(1, 1, 0, 1, 0, 0, 0, "t5.add0");
        step(0, 0, 2, 1, 0, 0, 0, "t5.use0");
        check_const("t5.r0fw", 2'b00, 2'b00, 1'b0);
        step(0, 0, 0, 1, 1, 0, 0, "t5.lw0");
        id_rs_i = 0; id_rt_i = 0; #1;
        check_const("t5.r0stall", 2'b00, 2'b00, 1'b0);
        step(0, 0, 3, 1, 0, 0, 0, "t5.use");

        // flushed producer is invisible
        do_reset();
        step(2, 3, 1, 1, 0, 1, 0, "t6.flush");
        step(1, 1, 4, 1, 0, 0, 0, "t6.use");
        check_const("t6.noflfw", 2'b00, 2'b00, 1'b0);
        // hold between producer and consumer
        do_reset();
        step(2, 3, 1, 1, 0, 0, 0, "t6.prod");
        step(1, 2, 4, 1, 0, 0, 0, "t6.cons");
        for (int i = 0; i < 3; i++) begin
            step(9, 9, 9, 1, 0, 0, 1, "t6.hold");
            check_const("t6.frozen", 2'b10, 2'b00, 1'b0);
        end
        nop("t6.rel");
        // stall and flush together: one bubble, load moves on normally
        do_reset();
        step(0, 0, 5, 1, 1, 0, 0, "t6.lw");
        step(5, 5, 6, 1, 0, 1, 0, "t6.stfl");
        step(5, 5, 6, 1, 0, 0, 0, "t6.cons2");
        check_const("t6.stfl_after", 2'b01, 2'b01, 1'b0);

        // randomized traffic over a small register window to provoke hazards
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) == 0) do_reset();
            step(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                 5'($urandom_range(0, 7)), 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 9) < 3), 1'($urandom_range(0, 9) == 0),
                 1'($urandom_range(0, 9) == 0), "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
